// File: rtl/dock_cfg_loader_if.sv
// Dock config-loader bus bundle: I/O gate, boot-ROM port, host write handshake, decoder write port and status.
// The slave modport is the loader; the master modport is the surrounding Dock logic.
interface dock_cfg_loader_if #(
  parameter int TBL_AW = 6
);
  logic              iorq_n;
  logic [TBL_AW-1:0] tbl_addr;
  logic [15:0]       tbl_data;
  logic              host_req;
  logic [7:0]        host_addr;
  logic [7:0]        host_wdata;
  logic              lock;
  logic              restart;
  logic              host_ack;
  logic              host_err;
  logic              cfg_we;
  logic [7:0]        cfg_addr;
  logic [7:0]        cfg_wdata;
  logic              loading;
  logic              boot_done;
  logic [TBL_AW:0]   entry_count;

  modport master (
    output iorq_n, tbl_data, host_req, host_addr, host_wdata, lock, restart,
    input  tbl_addr, host_ack, host_err, cfg_we, cfg_addr, cfg_wdata,
           loading, boot_done, entry_count
  );

  modport slave (
    input  iorq_n, tbl_data, host_req, host_addr, host_wdata, lock, restart,
    output tbl_addr, host_ack, host_err, cfg_we, cfg_addr, cfg_wdata,
           loading, boot_done, entry_count
  );
endinterface

// File: rtl/dock_cfg_loader.sv
// Replays the boot ROM into the decoder config port (1 write per 3 cycles, first on the 3rd edge), then serves host writes
// (registered ack/err, max 1 per 2 cycles); every write stalls while iorq_n is low and pending host requests wait outside S_READY.
module dock_cfg_loader #(
  parameter int TBL_DEPTH = 64,
  parameter int TBL_AW    = 6
) (
  input logic              clk,
  input logic              rst_n,
  dock_cfg_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2,
    S_READY = 2'd3
  } state_e;

  localparam logic [7:0]        END_MARK = 8'hFF;
  localparam logic [TBL_AW-1:0] IDX_LAST = TBL_AW'(TBL_DEPTH - 1);
  localparam logic [TBL_AW:0]   CNT_FULL = (TBL_AW + 1)'(TBL_DEPTH);

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [15:0]       pair_q, pair_d;
  logic              cfg_we_q, cfg_we_d;
  logic [7:0]        cfg_addr_q, cfg_addr_d;
  logic [7:0]        cfg_wdata_q, cfg_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              host_err_q, host_err_d;
  logic              boot_done_q, boot_done_d;
  logic [TBL_AW:0]   entry_count_q, entry_count_d;
  logic              host_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      idx_q         <= '0;
      pair_q        <= '0;
      cfg_we_q      <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_wdata_q   <= '0;
      host_ack_q    <= 1'b0;
      host_err_q    <= 1'b0;
      boot_done_q   <= 1'b0;
      entry_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pair_q        <= pair_d;
      cfg_we_q      <= cfg_we_d;
      cfg_addr_q    <= cfg_addr_d;
      cfg_wdata_q   <= cfg_wdata_d;
      host_ack_q    <= host_ack_d;
      host_err_q    <= host_err_d;
      boot_done_q   <= boot_done_d;
      entry_count_q <= entry_count_d;
    end
  end

  // A request still high in the ack/err cycle is the one just answered, not a new one.
  assign host_new = bus.host_req && !host_ack_q && !host_err_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pair_d        = pair_q;
    cfg_we_d      = 1'b0;
    cfg_addr_d    = cfg_addr_q;
    cfg_wdata_d   = cfg_wdata_q;
    host_ack_d    = 1'b0;
    host_err_d    = 1'b0;
    boot_done_d   = boot_done_q;
    entry_count_d = entry_count_q;

    case (state_q)
      S_FETCH: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (bus.tbl_data[15:8] == END_MARK) begin
          state_d       = S_READY;
          boot_done_d   = 1'b1;
          entry_count_d = {1'b0, idx_q};
        end else begin
          pair_d  = bus.tbl_data;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (bus.iorq_n) begin
          cfg_we_d    = 1'b1;
          cfg_addr_d  = pair_q[15:8];
          cfg_wdata_d = pair_q[7:0];
          // Full table ends on the last slot so idx never wraps back to 0.
          if (idx_q == IDX_LAST) begin
            state_d       = S_READY;
            boot_done_d   = 1'b1;
            entry_count_d = CNT_FULL;
          end else begin
            idx_d   = idx_q + TBL_AW'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_READY: begin
        if (bus.restart) begin
          idx_d       = '0;
          boot_done_d = 1'b0;
          state_d     = S_FETCH;
        end else if (host_new) begin
          if (bus.lock) begin
            host_err_d = 1'b1;
          end else if (bus.iorq_n) begin
            cfg_we_d    = 1'b1;
            cfg_addr_d  = bus.host_addr;
            cfg_wdata_d = bus.host_wdata;
            host_ack_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign bus.tbl_addr    = idx_q;
  assign bus.loading     = (state_q != S_READY);
  assign bus.cfg_we      = cfg_we_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.cfg_wdata   = cfg_wdata_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_err    = host_err_q;
  assign bus.boot_done   = boot_done_q;
  assign bus.entry_count = entry_count_q;

endmodule

// File: doc/dock_cfg_loader.md
Name: dock_cfg_loader

Overview:
- Single-clock sequencer that owns the address-decoder configuration write port (cfg_we/cfg_addr/cfg_wdata) on the Dock.
- After reset it replays a boot table of (cfg_addr, cfg_wdata) pairs from a synchronous ROM.
- Once the table is loaded, it arbitrates runtime host configuration writes.
- No config write is ever issued while an I/O cycle is in flight (iorq_n low), so decode never changes mid-cycle.
- The decoder's cfg_clk is tied to clk.

Parameters:
- TBL_DEPTH, 64, number of boot-table entries (power of 2, at most 256).
- TBL_AW, 6, boot-table address width, equal to log2(TBL_DEPTH).

Ports:
- clk  in  1  system clock; all logic rises on it.
- rst_n  in  1  asynchronous active-low reset.
- iorq_n  in  1  host I/O request, already synchronous to clk; 0 = I/O cycle active, config writes blocked.
- tbl_addr  out  TBL_AW  boot-ROM read address.
- tbl_data  in  16  boot-ROM data, valid 1 cycle after tbl_addr; [15:8] = cfg_addr, [7:0] = cfg_wdata; [15:8] = 8'hFF is the end marker.
- host_req  in  1  host config write request, level, held until host_ack or host_err.
- host_addr  in  8  host config address.
- host_wdata  in  8  host config data.
- lock  in  1  1 = host config writes refused.
- restart  in  1  1-cycle pulse: reload boot table.
- host_ack  out  1  1-cycle pulse: host write issued.
- host_err  out  1  1-cycle pulse: host write refused because of lock.
- cfg_we  out  1  config write strobe, 1-cycle pulse.
- cfg_addr  out  8  config address.
- cfg_wdata  out  8  config data.
- loading  out  1  1 while the boot table is being replayed.
- boot_done  out  1  1 once the boot table is complete.
- entry_count  out  TBL_AW+1  number of boot entries written during the last load.

Behaviour:
- Registered outputs: host_ack, host_err, cfg_we, cfg_addr, cfg_wdata, boot_done, entry_count. tbl_addr = idx register. loading = (state != S_READY), combinational.
- Reset state: state S_FETCH, idx 0, all registered outputs 0. loading = 1 during reset.
- S_FETCH: drive tbl_addr = idx. Next state is S_CHECK.
- S_CHECK: tbl_data is valid in this state.
  - If tbl_data[15:8] == 8'hFF: go to S_READY; boot_done <= 1; entry_count <= idx.
  - Otherwise latch the pair and go to S_WRITE.
- S_WRITE:
  - While iorq_n == 0: stall with no write.
  - When iorq_n == 1: cfg_we <= 1 and cfg_addr/cfg_wdata <= latched pair.
  - If idx == TBL_DEPTH-1: go to S_READY; boot_done <= 1; entry_count <= TBL_DEPTH (full table, no marker needed).
  - Otherwise idx <= idx + 1 and go to S_FETCH.
- Boot write rate: at most 1 write per 3 cycles. The first cfg_we rises no earlier than the 3rd rising edge after rst_n deasserts.
- S_READY, priority order at each edge:
  1. restart == 1: idx <= 0, boot_done <= 0, go to S_FETCH. Any pending host_req stays pending.
  2. host_req == 1, host_ack == 0, host_err == 0, lock == 1: host_err <= 1 and no write.
  3. host_req == 1, host_ack == 0, host_err == 0, lock == 0, iorq_n == 1: cfg_we <= 1, cfg_addr <= host_addr, cfg_wdata <= host_wdata, host_ack <= 1 (same cycle as cfg_we).
  4. host_req == 1, lock == 0, iorq_n == 0: wait with no ack.
- Host requests are never acked or errored outside S_READY; they stay pending.
- restart outside S_READY is ignored.
- Requester contract: after ack or err, the requester drops host_req or presents the next transaction. The cycle in which ack/err is high never accepts a new request, so the maximum host rate is 1 write per 2 cycles.
- cfg_addr/cfg_wdata hold their last values when cfg_we == 0.
- Asserting rst_n mid-load or mid-host-write aborts immediately. All outputs go to their reset values and the load restarts from idx 0 after release. There are no partial writes: cfg_we is 0 during reset.
- idx never wraps: the full-table case exits at TBL_DEPTH-1.

Test Plan:
- ROM {0:(0x00,0x12), 1:(0x01,0x34), 2:(0xFF,xx)}, iorq_n = 1 → cfg_we pulses with (0x00,0x12) then (0x01,0x34), 3 cycles apart; boot_done = 1 and loading = 0 afterwards; entry_count = 2.
- Same ROM, iorq_n = 0 for 5 cycles starting at the first S_WRITE → first cfg_we is delayed exactly until the cycle after iorq_n returns to 1; values unchanged.
- host_req with (0x20,0xAB) held from reset → no host_ack before boot_done; first cycle in S_READY gives cfg_we plus host_ack with cfg_addr = 0x20, cfg_wdata = 0xAB, both as 1-cycle pulses.
- lock = 1 with host_req (0x21,0x55) in S_READY → host_err 1-cycle pulse, cfg_we stays 0, cfg_addr unchanged.
- ROM full of non-0xFF entries (TBL_DEPTH = 64) → exactly 64 cfg_we pulses; entry_count = 64; tbl_addr never exceeds 63.
- restart pulse in S_READY → boot_done drops and the table replays identically. rst_n pulsed low while entry 1 is being loaded → outputs go to 0 asynchronously and the replay restarts from entry 0.
